// File: rtl/timer_pkg.sv
// Shared types and constants for the two-mode seconds timer.
package timer_pkg;

   localparam int unsigned PRE_W        = 25;
   localparam int unsigned SEC_W        = 13;
   localparam int unsigned TICK_DIV_DEF = 25000000;
   localparam int unsigned MAX_SEC_DEF  = 5999;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Clamp a preset to the terminal count.
   function automatic logic [SEC_W-1:0] sat_sec(input logic [SEC_W-1:0] v,
                                                input logic [SEC_W-1:0] max_v);
      return (v > max_v) ? max_v : v;
   endfunction

endpackage

// File: rtl/two_mode_timer_ctrl_inc.sv
// 25-bit combinational incrementor, wraps modulo 2^25.
module two_mode_timer_ctrl_inc
   import timer_pkg::*;
(
   input  logic [PRE_W-1:0] in_val,
   output logic [PRE_W-1:0] out_val
);

   assign out_val = in_val + PRE_W'(1);

endmodule

// File: rtl/two_mode_timer_ctrl.sv
// Stopwatch / countdown controller with one-second prescaler.
// Optional alarm output enabled by defining TIMER_ALARM_EN.
module two_mode_timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEF,
   parameter int unsigned MAX_SEC  = MAX_SEC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_stop,
   input  logic             clear,
   input  logic             mode,
   input  logic             load_en,
   input  logic [SEC_W-1:0] load_val,
   output logic [SEC_W-1:0] sec_count,
   output logic             tick,
   output logic             running,
   output logic             done,
   output logic             alarm
);

   localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICK_DIV - 1);
   localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(MAX_SEC);

   state_e           state_q, state_d;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d, pre_inc;
   logic [SEC_W-1:0] sec_q, sec_d, sec_step;
   logic             mode_q, mode_d;
   logic             tick_q, tick_d;
   logic             running_q, running_d;
   logic             done_q, done_d;
   logic             sec_term;

   two_mode_timer_ctrl_inc u_inc (
      .in_val  (pre_cnt_q),
      .out_val (pre_inc)
   );

`ifdef TIMER_ALARM_EN
   logic       alarm_q, alarm_d;
   logic [1:0] alarm_cnt_q, alarm_cnt_d;
`endif

   // Saturating one-second step; keeps sec_count inside 0..MAX_SEC even
   // when a preset already sits at the terminal value.
   always_comb begin
      if (mode_q) sec_step = (sec_q == '0) ? '0 : sec_q - SEC_W'(1);
      else        sec_step = (sec_q >= SEC_MAX) ? SEC_MAX : sec_q + SEC_W'(1);
      sec_term = mode_q ? (sec_step == '0) : (sec_step == SEC_MAX);
   end

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      sec_d     = sec_q;
      mode_d    = mode_q;
      tick_d    = 1'b0;
      done_d    = 1'b0;
`ifdef TIMER_ALARM_EN
      alarm_d     = alarm_q;
      alarm_cnt_d = alarm_cnt_q;
`endif
      if (clear) begin
         state_d   = ST_IDLE;
         pre_cnt_d = '0;
         sec_d     = '0;
`ifdef TIMER_ALARM_EN
         alarm_d     = 1'b0;
         alarm_cnt_d = '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               pre_cnt_d = '0;
               if (load_en) begin
                  sec_d = sat_sec(load_val, SEC_MAX);
               end else if (start_stop && !(mode && sec_q == '0)) begin
                  state_d = ST_RUN;
                  mode_d  = mode;
               end
            end
            ST_RUN: begin
               if (pre_cnt_q == PRE_TERM) begin
                  pre_cnt_d = '0;
                  tick_d    = 1'b1;
                  sec_d     = sec_step;
                  if (sec_term) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
`ifdef TIMER_ALARM_EN
                     alarm_d     = 1'b1;
                     alarm_cnt_d = '0;
`endif
                  end else if (start_stop) begin
                     state_d = ST_PAUSE;
                  end
               end else begin
                  pre_cnt_d = pre_inc;
                  if (start_stop) state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (load_en) begin
                  sec_d = sat_sec(load_val, SEC_MAX);
               end else if (start_stop) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               pre_cnt_d = '0;
`ifdef TIMER_ALARM_EN
               // Prescaler keeps counting seconds only while the alarm is up.
               if (start_stop) begin
                  alarm_d = 1'b0;
               end else if (alarm_q) begin
                  if (pre_cnt_q == PRE_TERM) begin
                     alarm_cnt_d = alarm_cnt_q + 2'd1;
                     if (alarm_cnt_q == 2'd2) alarm_d = 1'b0;
                  end else begin
                     pre_cnt_d = pre_inc;
                  end
               end
`endif
               if (start_stop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pre_cnt_q <= '0;
         sec_q     <= '0;
         mode_q    <= 1'b0;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         sec_q     <= sec_d;
         mode_q    <= mode_d;
         tick_q    <= tick_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

`ifdef TIMER_ALARM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alarm_q     <= 1'b0;
         alarm_cnt_q <= '0;
      end else begin
         alarm_q     <= alarm_d;
         alarm_cnt_q <= alarm_cnt_d;
      end
   end
   assign alarm = alarm_q;
`else
   assign alarm = 1'b0;
`endif

   assign sec_count = sec_q;
   assign tick      = tick_q;
   assign running   = running_q;
   assign done      = done_q;

endmodule

// File: tb/tb_two_mode_timer_ctrl.sv
// Directed bench for two_mode_timer_ctrl with TICK_DIV=4, MAX_SEC=5.
module tb_two_mode_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_stop = 1'b0, clear = 1'b0, mode = 1'b0, load_en = 1'b0;
   logic [12:0] load_val = '0;
   logic [12:0] sec_count;
   logic        tick, running, done, alarm;

   int errors = 0;
   int checks = 0;

`ifdef TIMER_ALARM_EN
   localparam logic ALARM_EN = 1'b1;
`else
   localparam logic ALARM_EN = 1'b0;
`endif

   two_mode_timer_ctrl #(.TICK_DIV(4), .MAX_SEC(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_stop (start_stop),
      .clear      (clear),
      .mode       (mode),
      .load_en    (load_en),
      .load_val   (load_val),
      .sec_count  (sec_count),
      .tick       (tick),
      .running    (running),
      .done       (done),
      .alarm      (alarm)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ss, clr, md, ld;
      logic [12:0] lv;
      logic [12:0] esec;
      logic        etick, erun, edone;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic ss, input logic clr, input logic md,
                               input logic ld, input logic [12:0] lv,
                               input logic [12:0] esec, input logic etick,
                               input logic erun, input logic edone);
      vec_t v;
      v.ss = ss; v.clr = clr; v.md = md; v.ld = ld; v.lv = lv;
      v.esec = esec; v.etick = etick; v.erun = erun; v.edone = edone;
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic ss, input logic clr, input logic md,
                        input logic ld, input logic [12:0] lv);
      start_stop = ss; clear = clr; mode = md; load_en = ld; load_val = lv;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0);
         step();
      end
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Count-up run to MAX_SEC, start_stop coinciding with the terminal tick.
      add(1, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int s = 1; s <= 5; s++) begin
         for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 13'(s - 1), 0, 1, 0);
         if (s < 5) add(0, 0, 0, 0, 0, 13'(s), 1, 1, 0);
         else       add(1, 0, 0, 0, 0, 5, 1, 0, 1);
      end
      add(0, 0, 0, 0, 0, 5, 0, 0, 0);
      add(1, 0, 0, 0, 0, 5, 0, 0, 0);     // DONE -> IDLE, count held
      // Loads, countdown with mode changes and load attempts mid-run.
      add(0, 0, 0, 1, 100, 5, 0, 0, 0);
      add(0, 0, 0, 1, 3, 3, 0, 0, 0);
      add(1, 0, 1, 0, 0, 3, 0, 1, 0);
      add(0, 0, 0, 1, 1, 3, 0, 1, 0);
      add(0, 0, 0, 0, 0, 3, 0, 1, 0);
      add(0, 0, 0, 0, 0, 3, 0, 1, 0);
      add(0, 0, 0, 0, 0, 2, 1, 1, 0);
      for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 2, 0, 1, 0);
      add(0, 0, 0, 0, 0, 1, 1, 1, 0);
      for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 0, 1, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0, 0, 0, 0);     // countdown from 0 refused
      add(1, 0, 0, 1, 2, 2, 0, 0, 0);     // load wins over start
      add(0, 1, 0, 0, 0, 0, 0, 0, 0);

      #12;
      chk("reset.sec", sec_count, 0);
      chk("reset.running", running, 0);
      chk("reset.tick", tick, 0);
      chk("reset.done", done, 0);
      chk("reset.alarm", alarm, 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      foreach (vq[i]) begin
         drive(vq[i].ss, vq[i].clr, vq[i].md, vq[i].ld, vq[i].lv);
         step();
         chk($sformatf("vec%0d.sec", i), sec_count, vq[i].esec);
         chk($sformatf("vec%0d.tick", i), tick, vq[i].etick);
         chk($sformatf("vec%0d.running", i), running, vq[i].erun);
         chk($sformatf("vec%0d.done", i), done, vq[i].edone);
      end

      // Pause after two RUN cycles, resume from the held prescaler.
      drive(1, 0, 0, 0, 0); step();
      chk("pause.start", running, 1);
      idle(1);
      drive(1, 0, 0, 0, 0); step();
      chk("pause.enter", running, 0);
      for (int k = 0; k < 10; k++) begin
         idle(1);
         chk("pause.hold_tick", tick, 0);
      end
      chk("pause.hold_sec", sec_count, 0);
      drive(1, 0, 0, 0, 0); step();
      chk("resume.running", running, 1);
      idle(1);
      chk("resume.plus1_tick", tick, 0);
      idle(1);
      chk("resume.plus2_tick", tick, 1);
      chk("resume.plus2_sec", sec_count, 1);

      // start_stop on a non-terminal tick: tick applied, then PAUSE.
      idle(3);
      drive(1, 0, 0, 0, 0); step();
      chk("tick_ss.sec", sec_count, 2);
      chk("tick_ss.tick", tick, 1);
      chk("tick_ss.running", running, 0);

      // clear coincident with a tick.
      drive(1, 0, 0, 0, 0); step();
      idle(3);
      drive(0, 1, 0, 0, 0); step();
      chk("clr_tick.sec", sec_count, 0);
      chk("clr_tick.tick", tick, 0);
      chk("clr_tick.running", running, 0);
      chk("clr_tick.done", done, 0);

      // Asynchronous reset mid-RUN discards the partial second.
      drive(1, 0, 0, 0, 0); step();
      idle(4);
      chk("prerst.sec", sec_count, 1);
      idle(1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async.sec", sec_count, 0);
      chk("rst_async.running", running, 0);
      chk("rst_async.tick", tick, 0);
      chk("rst_async.done", done, 0);
      chk("rst_async.alarm", alarm, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 0, 0, 0); step();
      chk("rst_restart.running", running, 1);
      idle(3);
      chk("rst_restart.no_early_tick", tick, 0);
      idle(1);
      chk("rst_restart.tick", tick, 1);
      chk("rst_restart.sec", sec_count, 1);

      // Alarm behaviour around DONE.
      drive(0, 1, 0, 0, 0); step();
      drive(0, 0, 0, 1, 1); step();
      drive(1, 0, 1, 0, 0); step();
      idle(4);
      chk("alarm_run.done", done, 1);
      chk("alarm_run.sec", sec_count, 0);
      chk("alarm.entry", alarm, 32'(ALARM_EN));
      for (int k = 1; k <= 12; k++) begin
         idle(1);
         chk($sformatf("alarm.cycle%0d", k), alarm, 32'(ALARM_EN && (k < 12)));
         if (k == 4) chk("alarm.no_tick_in_done", tick, 0);
      end
      drive(1, 0, 0, 0, 0); step();
      drive(0, 0, 0, 1, 1); step();
      drive(1, 0, 1, 0, 0); step();
      idle(4);
      chk("alarm2.done", done, 1);
      idle(1);
      chk("alarm2.still_high", alarm, 32'(ALARM_EN));
      drive(1, 0, 0, 0, 0); step();
      chk("alarm2.ss_drop", alarm, 0);
      chk("alarm2.idle_sec", sec_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/two_mode_timer_ctrl.md
TWO_MODE_TIMER_CTRL -- requirements
Module: two_mode_timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, clk cycles per one-second tick (2..33554432).
REQ-002 SHALL have parameter MAX_SEC, default 5999, terminal count-up value in seconds (1..8191).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start_stop  in  1  one-cycle pulse; start/pause/resume/acknowledge.
REQ-006 clear  in  1  one-cycle pulse; abort to IDLE, zero count.
REQ-007 mode  in  1  0 = count-up stopwatch, 1 = countdown.
REQ-008 load_en  in  1  one-cycle pulse; load load_val into seconds count.
REQ-009 load_val  in  13  seconds preset.
REQ-010 sec_count  out  13  current seconds value, registered.
REQ-011 tick  out  1  one-cycle pulse per elapsed second while running.
REQ-012 running  out  1  high when state is RUN.
REQ-013 done  out  1  one-cycle pulse on entry to DONE.
REQ-014 alarm  out  1  alarm indication (see Configuration).

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE, DONE; IDLE after reset.
REQ-016 SHALL keep a 25-bit prescaler pre_cnt, incremented in RUN only through the incrementor sub-module; no other adder on pre_cnt.
REQ-017 In RUN, pre_cnt == TICK_DIV-1 SHALL set pre_cnt to 0 and assert tick at that edge; otherwise pre_cnt takes the incremented value.
REQ-018 pre_cnt SHALL hold in PAUSE and be zeroed in IDLE and DONE.
REQ-019 On the edge asserting tick, sec_count SHALL update on that same edge: +1 if mode_q=0, -1 if mode_q=1.
REQ-020 mode SHALL be captured into mode_q only on the IDLE->RUN transition; later mode changes are ignored until next IDLE.
REQ-021 IDLE: start_stop -> RUN, except mode=1 with sec_count=0 stays IDLE.
REQ-022 RUN: start_stop -> PAUSE; tick taking sec_count to MAX_SEC (up) or 0 (down) -> DONE.
REQ-023 PAUSE: start_stop -> RUN, pre_cnt resumes from held value.
REQ-024 DONE: sec_count holds terminal value; start_stop -> IDLE with sec_count held.
REQ-025 clear SHALL have top priority in every state: next state IDLE, sec_count 0, pre_cnt 0.
REQ-026 load_en SHALL be accepted in IDLE and PAUSE only: sec_count <= min(load_val, MAX_SEC); it is ignored in RUN and DONE.
REQ-027 load_en and start_stop in the same cycle: load applied, start_stop ignored.
REQ-028 In RUN, start_stop coinciding with a terminal tick SHALL go to DONE, not PAUSE; with a non-terminal tick, the tick is applied and the state goes to PAUSE.
REQ-029 sec_count SHALL never leave 0..MAX_SEC; no wrap-around.
REQ-030 done SHALL pulse exactly once per DONE entry.

Reset
REQ-031 rst SHALL asynchronously force state IDLE, pre_cnt 0, mode_q 0, sec_count 0, tick 0, running 0, done 0, alarm 0.
REQ-032 rst mid-RUN SHALL discard the partial second; the first tick after restart comes TICK_DIV cycles after RUN entry.

Configuration
REQ-033 With TIMER_ALARM_EN defined, alarm SHALL assert on DONE entry and stay high for 3 ticks (prescaler keeps running in DONE for this) or until start_stop/clear/rst, whichever is first.
REQ-034 Without TIMER_ALARM_EN, alarm SHALL be tied 0 and no alarm logic SHALL be synthesized; all other behaviour is identical.

Structure
REQ-035 Package timer_pkg SHALL hold the state enum, the 25-bit prescaler width constant, and the default TICK_DIV/MAX_SEC constants.
REQ-036 SHALL instantiate exactly one sub-module: the team's 25-bit combinational incrementor (out = in+1, modulo 2^25) for pre_cnt.

Verification (TICK_DIV=4, MAX_SEC=5 unless stated)
REQ-037 mode=0, start_stop -> tick every 4 cycles, sec_count 1..5, done pulse once at 5, running falls the same edge.
REQ-038 Load 3, mode=1, start -> sec_count 2,1,0, then DONE; start_stop with sec_count=0 in IDLE remains IDLE.
REQ-039 Pause after 2 cycles, hold 10 cycles, resume -> next tick 2 cycles after resume.
REQ-040 load_val=100 in IDLE -> sec_count=5; load_en during RUN -> no change.
REQ-041 clear during RUN coincident with tick -> IDLE, sec_count 0, no done; rst mid-RUN -> all outputs 0 immediately.
REQ-042 With TIMER_ALARM_EN: alarm high for 12 cycles after DONE; start_stop in DONE drops alarm next edge.
